usb_bulk_mux_axis: RTL and testbench



---
 rtl/usb_bulk_mux_axis.sv | 194 +++++++++++++++++++
 tb/tb_usb_bulk_mux_axis.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bulk_mux_axis.sv
// Multiplexes CHANNELS byte streams onto one USB bulk IN stream (header + segmentation)
// and routes header-tagged bulk OUT packets to per-channel sinks.
module usb_bulk_mux_axis #(
    parameter int CHANNELS = 4,
    parameter int MAX_SEG  = 512
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   s_axis_tvalid_i,
    output logic [CHANNELS-1:0]   s_axis_tready_o,
    input  logic [CHANNELS-1:0]   s_axis_tlast_i,
    input  logic [8*CHANNELS-1:0] s_axis_tdata_i,
    output logic                  usb_tvalid_o,
    input  logic                  usb_tready_i,
    output logic                  usb_tlast_o,
    output logic [7:0]            usb_tdata_o,
    input  logic                  usb_tvalid_i,
    output logic                  usb_tready_o,
    input  logic                  usb_tlast_i,
    input  logic [7:0]            usb_tdata_i,
    output logic [CHANNELS-1:0]   m_axis_tvalid_o,
    input  logic [CHANNELS-1:0]   m_axis_tready_i,
    output logic [CHANNELS-1:0]   m_axis_tlast_o,
    output logic [7:0]            m_axis_tdata_o
);
    localparam int CW   = $clog2(CHANNELS);
    localparam int CNTW = $clog2(MAX_SEG);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_SEG - 1);

    typedef enum logic [1:0] {IN_IDLE, IN_HEAD, IN_DATA} in_state_t;
    typedef enum logic [1:0] {OUT_HDR, OUT_PASS, OUT_DROP} out_state_t;

    in_state_t           in_state_reg;
    logic [CW-1:0]       rr_reg;
    logic [CW-1:0]       sel_reg;
    logic [CNTW-1:0]     cnt_reg;
    logic [CHANNELS-1:0] cont_reg;
    logic [7:0]          hdr_reg;

    logic [7:0]          src_data [CHANNELS];
    logic                src_valid;
    logic                src_last;
    logic                seg_full;
    logic                in_xfer;
    logic                pick_found;
    logic [CW-1:0]       pick_idx;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_src
            assign src_data[gi]        = s_axis_tdata_i[8*gi +: 8];
            assign s_axis_tready_o[gi] = (in_state_reg == IN_DATA) && (sel_reg == CW'(gi)) && usb_tready_i;
        end
    endgenerate

    assign src_valid = s_axis_tvalid_i[sel_reg];
    assign src_last  = s_axis_tlast_i[sel_reg];
    assign seg_full  = (cnt_reg == CNT_LAST);
    assign in_xfer   = (in_state_reg == IN_DATA) && src_valid && usb_tready_i;

    // Round-robin search starts one past the channel that last finished a segment.
    always_comb begin : p_arb
        int          idx;
        logic [CW-1:0] idx_c;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_c      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx   = (int'(rr_reg) + i) % CHANNELS;
            idx_c = CW'(idx);
            if (!pick_found && s_axis_tvalid_i[idx_c]) begin
                pick_found = 1'b1;
                pick_idx   = idx_c;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_state_reg <= IN_IDLE;
            rr_reg       <= CW'(CHANNELS - 1);
            sel_reg      <= '0;
            cnt_reg      <= '0;
            cont_reg     <= '0;
            hdr_reg      <= '0;
        end else begin
            case (in_state_reg)
                IN_IDLE: begin
                    if (pick_found) begin
                        sel_reg      <= pick_idx;
                        hdr_reg      <= {cont_reg[pick_idx], 7'(pick_idx)};
                        in_state_reg <= IN_HEAD;
                    end
                end
                IN_HEAD: begin
                    if (usb_tready_i) begin
                        cnt_reg      <= '0;
                        in_state_reg <= IN_DATA;
                    end
                end
                IN_DATA: begin
                    if (in_xfer) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // Source tlast wins over the cap so a frame ending exactly on the cap is not continued.
                        if (src_last) begin
                            cont_reg[sel_reg] <= 1'b0;
                            rr_reg            <= sel_reg;
                            in_state_reg      <= IN_IDLE;
                        end else if (seg_full) begin
                            cont_reg[sel_reg] <= 1'b1;
                            rr_reg            <= sel_reg;
                            in_state_reg      <= IN_IDLE;
                        end
                    end
                end
                default: in_state_reg <= IN_IDLE;
            endcase
        end
    end

    always_comb begin
        usb_tvalid_o = 1'b0;
        usb_tlast_o  = 1'b0;
        usb_tdata_o  = '0;
        case (in_state_reg)
            IN_HEAD: begin
                usb_tvalid_o = 1'b1;
                usb_tdata_o  = hdr_reg;
            end
            IN_DATA: begin
                usb_tvalid_o = src_valid;
                usb_tdata_o  = src_data[sel_reg];
                usb_tlast_o  = src_valid && (src_last || seg_full);
            end
            default: ;
        endcase
    end

    out_state_t          out_state_reg;
    logic [2:0]          ch_reg;
    logic                fin_reg;
    logic                run_reg;
    logic [CHANNELS-1:0] route;
    logic                sink_ready;
    logic                out_xfer;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sink
            assign route[gi]           = (out_state_reg == OUT_PASS) && (ch_reg == 3'(gi));
            assign m_axis_tvalid_o[gi] = route[gi] && usb_tvalid_i;
            assign m_axis_tlast_o[gi]  = route[gi] && usb_tvalid_i && usb_tlast_i && fin_reg;
        end
    endgenerate

    assign sink_ready     = |(route & m_axis_tready_i);
    assign m_axis_tdata_o = (out_state_reg == OUT_PASS) ? usb_tdata_i : 8'h00;
    assign out_xfer       = usb_tvalid_i && usb_tready_o;

    // run_reg keeps the header-stage ready low while (and just after) reset is applied.
    always_comb begin
        case (out_state_reg)
            OUT_HDR:  usb_tready_o = run_reg;
            OUT_PASS: usb_tready_o = sink_ready;
            OUT_DROP: usb_tready_o = 1'b1;
            default:  usb_tready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_state_reg <= OUT_HDR;
            ch_reg        <= '0;
            fin_reg       <= 1'b0;
            run_reg       <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            case (out_state_reg)
                OUT_HDR: begin
                    if (out_xfer) begin
                        ch_reg  <= usb_tdata_i[2:0];
                        fin_reg <= usb_tdata_i[7];
                        if (!usb_tlast_i)
                            out_state_reg <= (int'(usb_tdata_i[2:0]) < CHANNELS) ? OUT_PASS : OUT_DROP;
                    end
                end
                OUT_PASS, OUT_DROP: begin
                    if (out_xfer && usb_tlast_i)
                        out_state_reg <= OUT_HDR;
                end
                default: out_state_reg <= OUT_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_bulk_mux_axis.sv
// Scoreboard bench for usb_bulk_mux_axis: per-channel expected queues built from
// frame/packet rules, checked by a monitor decoupled from the stimulus drivers.
`timescale 1ns/1ps
module tb_usb_bulk_mux_axis;
    localparam int CHANNELS = 4;
    localparam int MAX_SEG  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [CHANNELS-1:0]   s_axis_tvalid_i = '0;
    logic [CHANNELS-1:0]   s_axis_tready_o;
    logic [CHANNELS-1:0]   s_axis_tlast_i = '0;
    logic [8*CHANNELS-1:0] s_axis_tdata_i = '0;
    logic                  usb_tvalid_o;
    logic                  usb_tready_i = 1'b0;
    logic                  usb_tlast_o;
    logic [7:0]            usb_tdata_o;
    logic                  usb_tvalid_i = 1'b0;
    logic                  usb_tready_o;
    logic                  usb_tlast_i = 1'b0;
    logic [7:0]            usb_tdata_i = '0;
    logic [CHANNELS-1:0]   m_axis_tvalid_o;
    logic [CHANNELS-1:0]   m_axis_tready_i = '0;
    logic [CHANNELS-1:0]   m_axis_tlast_o;
    logic [7:0]            m_axis_tdata_o;

    usb_bulk_mux_axis #(.CHANNELS(CHANNELS), .MAX_SEG(MAX_SEG)) dut (
        .clock(clock), .reset(reset),
        .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tready_o(s_axis_tready_o),
        .s_axis_tlast_i(s_axis_tlast_i), .s_axis_tdata_i(s_axis_tdata_i),
        .usb_tvalid_o(usb_tvalid_o), .usb_tready_i(usb_tready_i),
        .usb_tlast_o(usb_tlast_o), .usb_tdata_o(usb_tdata_o),
        .usb_tvalid_i(usb_tvalid_i), .usb_tready_o(usb_tready_o),
        .usb_tlast_i(usb_tlast_i), .usb_tdata_i(usb_tdata_i),
        .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tready_i(m_axis_tready_i),
        .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tdata_o(m_axis_tdata_o)
    );

    always #5 clock = ~clock;

    typedef logic [8:0] beat_t;            // {last, data}
    beat_t       src_q  [CHANNELS][$];
    beat_t       exp_in [CHANNELS][$];
    beat_t       out_src[$];
    logic [11:0] exp_out[$];               // {ch[2:0], last, data}
    logic [7:0]  hdr_log[$];

    int errors = 0;
    int checks = 0;
    bit rand_bp = 0, gap_en = 0, hold_in = 0, m_seen = 0, in_seg = 0;
    int cur_ch = 0;
    logic [CHANNELS-1:0] s_fire = '0;
    bit u_fire = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Expected IN stream: frame split into MAX_SEG chunks, each led by a header.
    task automatic send_in(input int ch, input int len, input bit rnd, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(int'(base) * (i + 1));
            src_q[ch].push_back({i == len - 1, b});
            if (i % MAX_SEG == 0)
                exp_in[ch].push_back({1'b0, (i > 0) ? 1'b1 : 1'b0, 7'(ch)});
            exp_in[ch].push_back({(i == len - 1) || (i % MAX_SEG == MAX_SEG - 1), b});
        end
        $display("IN  frame ch=%0d len=%0d", ch, len);
    endtask

    task automatic send_out(input logic [7:0] hdr, input int len, input logic [7:0] b0,
                            input logic [7:0] b1, input bit rnd);
        logic [7:0] b;
        out_src.push_back({len == 0, hdr});
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : ((i == 0) ? b0 : b1);
            out_src.push_back({i == len - 1, b});
            if (int'(hdr[2:0]) < CHANNELS)
                exp_out.push_back({hdr[2:0], (i == len - 1) && hdr[7], b});
        end
        $display("OUT packet hdr=%02h len=%0d", hdr, len);
    endtask

    function automatic bit busy();
        bit b;
        b = in_seg || (out_src.size() != 0) || (exp_out.size() != 0);
        for (int k = 0; k < CHANNELS; k++)
            b = b || (src_q[k].size() != 0) || (exp_in[k].size() != 0);
        return b;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 5000 && busy()) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL %s_drain got=busy_after_%0d_cycles expected=idle", name, n);
        end
        repeat (4) @(posedge clock);
        #2;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_s_tready"}, 32'(s_axis_tready_o), 0);
        chk({name, "_usb_in_vlast"}, {30'd0, usb_tvalid_o, usb_tlast_o}, 0);
        chk({name, "_usb_tdata"}, 32'(usb_tdata_o), 0);
        chk({name, "_usb_tready"}, 32'(usb_tready_o), 0);
        chk({name, "_m_valid_last"}, {24'd0, m_axis_tvalid_o, m_axis_tlast_o}, 0);
        chk({name, "_m_tdata"}, 32'(m_axis_tdata_o), 0);
    endtask

    task automatic in_compare(input string name, input int ch, input beat_t got);
        beat_t e;
        checks++;
        if (exp_in[ch].size() == 0) begin
            errors++;
            $display("FAIL %s ch=%0d got=%03h expected=none", name, ch, got);
        end else begin
            e = exp_in[ch].pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s ch=%0d got=%03h expected=%03h", name, ch, got, e);
            end
        end
    endtask

    // Drivers: all inputs change 1ns after the rising edge; valid is held until accepted.
    initial begin : drv
        beat_t f;
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < CHANNELS; k++) begin
                if (s_fire[k] && !hold_in && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (hold_in || src_q[k].size() == 0) begin
                    s_axis_tvalid_i[k] = 1'b0;
                    s_axis_tlast_i[k]  = 1'b0;
                    s_axis_tdata_i[8*k +: 8] = 8'h00;
                end else begin
                    if (!(s_axis_tvalid_i[k] && !s_fire[k]))
                        s_axis_tvalid_i[k] = !gap_en || ($urandom_range(0, 3) != 0);
                    f = src_q[k][0];
                    s_axis_tlast_i[k] = f[8];
                    s_axis_tdata_i[8*k +: 8] = f[7:0];
                end
                m_axis_tready_i[k] = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            usb_tready_i = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (u_fire && out_src.size() > 0) void'(out_src.pop_front());
            if (out_src.size() == 0) begin
                usb_tvalid_i = 1'b0;
                usb_tlast_i  = 1'b0;
                usb_tdata_i  = 8'h00;
            end else begin
                if (!(usb_tvalid_i && !u_fire))
                    usb_tvalid_i = !gap_en || ($urandom_range(0, 3) != 0);
                f = out_src[0];
                usb_tlast_i = f[8];
                usb_tdata_i = f[7:0];
            end
        end
    end

    // Monitor: samples handshakes on the falling edge, i.e. the values the next rising edge commits.
    initial begin : mon
        logic [11:0] e;
        forever begin
            @(negedge clock);
            s_fire = s_axis_tvalid_i & s_axis_tready_o;
            u_fire = usb_tvalid_i && usb_tready_o;
            if (|m_axis_tvalid_o) m_seen = 1;
            if (!hold_in && !reset && usb_tvalid_o && usb_tready_i) begin
                if (!in_seg) begin
                    checks++;
                    if (usb_tdata_o[6:2] != 0 || usb_tlast_o) begin
                        errors++;
                        $display("FAIL in_hdr_format got=%02h last=%0b expected=valid_header", usb_tdata_o, usb_tlast_o);
                    end else begin
                        cur_ch = int'(usb_tdata_o[1:0]);
                        hdr_log.push_back(usb_tdata_o);
                        in_seg = 1;
                        in_compare("in_hdr", cur_ch, {usb_tlast_o, usb_tdata_o});
                    end
                end else begin
                    in_compare("in_data", cur_ch, {usb_tlast_o, usb_tdata_o});
                    if (usb_tlast_o) in_seg = 0;
                end
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (!reset && m_axis_tvalid_o[k] && m_axis_tready_i[k]) begin
                    checks++;
                    if (exp_out.size() == 0) begin
                        errors++;
                        $display("FAIL out_beat ch=%0d got=%02h expected=none", k, m_axis_tdata_o);
                    end else begin
                        e = exp_out.pop_front();
                        if ({3'(k), m_axis_tlast_o[k], m_axis_tdata_o} !== e) begin
                            errors++;
                            $display("FAIL out_beat got=%03h expected=%03h", {3'(k), m_axis_tlast_o[k], m_axis_tdata_o}, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] rr_exp [6];
        int n;
        rr_exp = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h01, 8'h03};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle("reset");
        @(posedge clock);
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;

        // Round-robin from reset: ch0, ch1, ch3 contending with two 1-byte frames each
        hdr_log.delete();
        send_in(0, 1, 1, 0); send_in(0, 1, 1, 0);
        send_in(1, 1, 1, 0); send_in(1, 1, 1, 0);
        send_in(3, 1, 1, 0); send_in(3, 1, 1, 0);
        drain("rr");
        for (int i = 0; i < 6; i++)
            chk($sformatf("rr_hdr%0d", i), (hdr_log.size() > i) ? 32'(hdr_log[i]) : 32'h1ff, 32'(rr_exp[i]));

        // Single frame on ch2: 02,11,22,33
        hdr_log.delete();
        send_in(2, 3, 0, 8'h11);
        drain("single");
        chk("single_hdr", (hdr_log.size() > 0) ? 32'(hdr_log[0]) : 32'h1ff, 32'h02);

        // Segmentation: 6-byte frame, then a frame ending exactly on the cap, then a fresh one
        hdr_log.delete();
        send_in(1, 6, 1, 0);
        send_in(1, 4, 1, 0);
        send_in(1, 1, 1, 0);
        drain("seg");
        chk("seg_hdr_count", 32'(hdr_log.size()), 4);

        // OUT routing
        send_out(8'h83, 2, 8'hAA, 8'hBB, 0);
        send_out(8'h03, 1, 8'hCC, 8'h00, 0);
        drain("route");

        // OUT drop and empty packets
        m_seen = 0;
        send_out(8'h05, 2, 8'h12, 8'h34, 0);
        send_out(8'h81, 0, 8'h00, 8'h00, 0);
        drain("drop");
        chk("drop_no_valid", 32'(m_seen), 0);

        // Random traffic with backpressure and source gaps on both directions
        rand_bp = 1;
        gap_en  = 1;
        for (int i = 0; i < 40; i++) begin
            send_in($urandom_range(0, CHANNELS - 1), $urandom_range(1, 10), 1, 0);
            send_out(8'($urandom) & 8'h87, $urandom_range(0, 5), 8'h00, 8'h00, 1);
        end
        drain("random");

        // Reset while a continuation segment of ch1 is in flight
        hdr_log.delete();
        send_in(1, 8, 1, 0);
        n = 0;
        do begin
            @(posedge clock);
            #2;
            n++;
        end while (n < 3000 && !(hdr_log.size() >= 2 && in_seg));
        chk("reset_wait_cont_seg", 32'(n < 3000), 1);
        hold_in = 1;
        reset   = 1'b1;
        src_q[1].delete();
        exp_in[1].delete();
        in_seg  = 0;
        @(posedge clock);
        @(negedge clock);
        check_idle("mid_reset");
        @(posedge clock);
        #2;
        reset   = 1'b0;
        hold_in = 0;
        hdr_log.delete();
        send_in(1, 2, 1, 0);
        drain("post_reset");
        chk("post_reset_hdr", (hdr_log.size() > 0) ? 32'(hdr_log[0]) : 32'h1ff, 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
